// File: rtl/pw_trigger_monitor.sv
// Receive-side trigger monitor: synchronizes an asynchronous trigger line and measures
// start-to-rise delay, high width and rising-edge count, holding each result until acked.
module pw_trigger_monitor #(
    parameter int unsigned pDELAY_WIDTH = 20,
    parameter int unsigned pWIDTH_WIDTH = 17,
    parameter int unsigned pSYNC_STAGES = 2,
    parameter int unsigned pCOUNT_WIDTH = 16
) (
    input  logic                    trigger_clk,
    input  logic                    reset_n_i,
    input  logic                    I_trigger,
    input  logic                    I_start,
    input  logic                    I_arm,
    input  logic                    I_ack,
    output logic [pDELAY_WIDTH-1:0] O_delay,
    output logic [pWIDTH_WIDTH-1:0] O_width,
    output logic [1:0]              O_overflow,
    output logic                    O_valid,
    output logic                    O_busy,
    output logic [pCOUNT_WIDTH-1:0] O_trig_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        DONE
    } state_t;

    state_t                  state_q;
    logic [pSYNC_STAGES-1:0] sync_q;
    logic                    trig_d_q;
    logic                    trig_s;
    logic                    rise_det;
    logic                    fall_det;
    logic [pDELAY_WIDTH-1:0] dcnt_q;
    logic [pWIDTH_WIDTH-1:0] wcnt_q;
    logic [pDELAY_WIDTH-1:0] delay_q;
    logic [pWIDTH_WIDTH-1:0] width_q;
    logic [1:0]              ovf_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [pCOUNT_WIDTH-1:0] count_q;
    logic [pCOUNT_WIDTH-1:0] count_d;

    // Rise and fall see the same pipeline depth, so the width is not skewed.
    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q   <= '0;
            trig_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[pSYNC_STAGES-2:0], I_trigger};
            trig_d_q <= sync_q[pSYNC_STAGES-1];
        end
    end

    assign trig_s   = sync_q[pSYNC_STAGES-1];
    assign rise_det = trig_s & ~trig_d_q;
    assign fall_det = ~trig_s & trig_d_q;

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            delay_q <= '0;
            width_q <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (I_start && I_arm) begin
                        state_q <= WAIT_RISE;
                        busy_q  <= 1'b1;
                        dcnt_q  <= pDELAY_WIDTH'(1);
                        ovf_q   <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (!I_arm) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (I_start) begin
                        dcnt_q <= pDELAY_WIDTH'(1);
                        ovf_q  <= '0;
                    end else if (rise_det) begin
                        delay_q <= dcnt_q;
                        wcnt_q  <= pWIDTH_WIDTH'(1);
                        state_q <= HIGH;
                    end else if (dcnt_q == '1) begin
                        ovf_q[0] <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + pDELAY_WIDTH'(1);
                    end
                end
                HIGH: begin
                    if (!I_arm) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (fall_det) begin
                        width_q <= wcnt_q;
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (wcnt_q == '1) begin
                        ovf_q[1] <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + pWIDTH_WIDTH'(1);
                    end
                end
                DONE: begin
                    // Result is held regardless of arm; only an ack releases it.
                    if (I_ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (rise_det && I_arm) begin
            count_d = count_q + pCOUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign O_delay      = delay_q;
    assign O_width      = width_q;
    assign O_overflow   = ovf_q;
    assign O_valid      = valid_q;
    assign O_busy       = busy_q;
    assign O_trig_count = count_q;

endmodule

// File: tb/tb_pw_trigger_monitor.sv
// Directed bench for pw_trigger_monitor: default instance plus a 4-bit delay instance
// for the saturation case.
module tb_pw_trigger_monitor;

    logic        clk;
    logic        rst_n;
    logic        trig, start, arm, ack;
    logic        trig_b, start_b, ack_b;

    logic [19:0] delay_a;
    logic [16:0] width_a;
    logic [1:0]  ovf_a;
    logic        valid_a, busy_a;
    logic [15:0] cnt_a;

    logic [3:0]  delay_b;
    logic [16:0] width_b;
    logic [1:0]  ovf_b;
    logic        valid_b, busy_b;
    logic [15:0] cnt_b;

    int unsigned total;
    int unsigned fails;

    pw_trigger_monitor dut_a (
        .trigger_clk (clk),
        .reset_n_i   (rst_n),
        .I_trigger   (trig),
        .I_start     (start),
        .I_arm       (arm),
        .I_ack       (ack),
        .O_delay     (delay_a),
        .O_width     (width_a),
        .O_overflow  (ovf_a),
        .O_valid     (valid_a),
        .O_busy      (busy_a),
        .O_trig_count(cnt_a)
    );

    pw_trigger_monitor #(.pDELAY_WIDTH(4)) dut_b (
        .trigger_clk (clk),
        .reset_n_i   (rst_n),
        .I_trigger   (trig_b),
        .I_start     (start_b),
        .I_arm       (arm),
        .I_ack       (ack_b),
        .O_delay     (delay_b),
        .O_width     (width_b),
        .O_overflow  (ovf_b),
        .O_valid     (valid_b),
        .O_busy      (busy_b),
        .O_trig_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        fails = 0;
        rst_n = 1'b0;
        trig = 0; start = 0; arm = 0; ack = 0;
        trig_b = 0; start_b = 0; ack_b = 0;

        tick(3);
        chk("rst_delay", 32'(delay_a), 0);
        chk("rst_width", 32'(width_a), 0);
        chk("rst_ovf",   32'(ovf_a),   0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_busy",  32'(busy_a),  0);
        chk("rst_count", 32'(cnt_a),   0);
        rst_n = 1'b1;
        arm   = 1'b1;
        tick(2);

        // Basic measurement: rise detected 100 cycles after start, width 50
        start = 1; tick(1); start = 0;
        chk("t1_busy", 32'(busy_a), 1);
        tick(97); trig = 1;
        tick(50); trig = 0;
        tick(2);
        chk("t1_valid_early", 32'(valid_a), 0);
        tick(1);
        chk("t1_delay", 32'(delay_a), 100);
        chk("t1_width", 32'(width_a), 50);
        chk("t1_valid", 32'(valid_a), 1);
        chk("t1_ovf",   32'(ovf_a),   0);
        chk("t1_count", 32'(cnt_a),   1);
        chk("t1_busy_done", 32'(busy_a), 0);

        // DONE holds the result against starts and new edges
        start = 1; tick(1); start = 0; tick(1);
        trig = 1; tick(5); trig = 0; tick(5);
        chk("t3_delay", 32'(delay_a), 100);
        chk("t3_width", 32'(width_a), 50);
        chk("t3_valid", 32'(valid_a), 1);
        chk("t3_busy",  32'(busy_a),  0);
        chk("t3_count", 32'(cnt_a),   2);
        ack = 1; start = 1; tick(1); ack = 0; start = 0;
        chk("t3_ack_valid", 32'(valid_a), 0);
        chk("t3_ack_busy",  32'(busy_a),  0);
        tick(1);
        chk("t3_start_dropped", 32'(busy_a), 0);

        // Restart 30 cycles in, rise 40 cycles after the first start
        start = 1; tick(1); start = 0;
        tick(29);
        start = 1; tick(1); start = 0;
        tick(7); trig = 1;
        tick(20); trig = 0;
        tick(3);
        chk("t5_delay", 32'(delay_a), 10);
        chk("t5_width", 32'(width_a), 20);
        chk("t5_valid", 32'(valid_a), 1);
        chk("t5_count", 32'(cnt_a),   3);
        ack = 1; tick(1); ack = 0;
        chk("t5_ack", 32'(valid_a), 0);

        // Arm dropped mid-HIGH aborts without a result
        start = 1; tick(1); start = 0;
        tick(5); trig = 1;
        tick(5);
        chk("t4_busy_high", 32'(busy_a),  1);
        chk("t4_delay",     32'(delay_a), 8);
        arm = 0; tick(1);
        chk("t4_busy_abort",  32'(busy_a),  0);
        chk("t4_valid_abort", 32'(valid_a), 0);
        chk("t4_count",       32'(cnt_a),   4);
        trig = 0; tick(4); trig = 1; tick(4); trig = 0; tick(4);
        chk("t4_count_disarmed", 32'(cnt_a), 4);
        chk("t4_idle", 32'(busy_a), 0);
        arm = 1; tick(4);

        // 4-bit delay counter saturates at 15
        start_b = 1; tick(1); start_b = 0;
        tick(17); trig_b = 1;
        tick(6); trig_b = 0;
        tick(3);
        chk("t2_delay", 32'(delay_b), 15);
        chk("t2_ovf",   32'(ovf_b),   1);
        chk("t2_width", 32'(width_b), 6);
        chk("t2_valid", 32'(valid_b), 1);
        ack_b = 1; tick(1); ack_b = 0;

        // Asynchronous reset mid-HIGH
        start = 1; tick(1); start = 0;
        tick(2); trig = 1;
        tick(6);
        chk("t6_busy_pre", 32'(busy_a), 1);
        #2; rst_n = 0; #1;
        chk("t6_delay", 32'(delay_a), 0);
        chk("t6_width", 32'(width_a), 0);
        chk("t6_ovf",   32'(ovf_a),   0);
        chk("t6_valid", 32'(valid_a), 0);
        chk("t6_busy",  32'(busy_a),  0);
        chk("t6_count", 32'(cnt_a),   0);
        trig = 0;
        tick(1);
        rst_n = 1;
        tick(2);
        start = 1; tick(1); start = 0;
        tick(9); trig = 1;
        tick(7); trig = 0;
        tick(3);
        chk("t6_post_delay", 32'(delay_a), 12);
        chk("t6_post_width", 32'(width_a), 7);
        chk("t6_post_valid", 32'(valid_a), 1);
        chk("t6_post_ovf",   32'(ovf_a),   0);
        chk("t6_post_count", 32'(cnt_a),   1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
